// File: rtl/game_period_ctrl_pkg.sv
// game_pkg: shared state encoding and default widths for the game-period controller
package game_pkg;

    localparam int SEC_W     = 8;
    localparam int DEF_SYM_W = 8;

    localparam logic [DEF_SYM_W-1:0] DEF_HIST_INIT = 8'h01;

    typedef enum logic [1:0] {
        GS_IDLE   = 2'd0,
        GS_RUN    = 2'd1,
        GS_ANSWER = 2'd2
    } game_state_e;

endpackage

// File: rtl/game_period_ctrl_if.sv
// game_period_ctrl_if: control, symbol and display signals between game FSM and period controller
interface game_period_ctrl_if
    import game_pkg::*;
#(
    parameter int SYM_W      = DEF_SYM_W,
    parameter int CNT_W      = 8,
    parameter int HIST_DEPTH = 4
) ();

    logic                        gameSig;
    logic                        abortSig;
    logic                        answerAck;
    logic                        symValid;
    logic                        symSpecial;
    logic [SYM_W-1:0]            symData;
    logic                        startGen;
    logic                        stopGen;
    logic                        genEnable;
    logic                        answerSig;
    logic [CNT_W-1:0]            numSpecial;
    logic [SEC_W-1:0]            gameTime;
    logic [HIST_DEPTH*SYM_W-1:0] gameHist;

    modport master (
        output gameSig, abortSig, answerAck, symValid, symSpecial, symData,
        input  startGen, stopGen, genEnable, answerSig, numSpecial, gameTime, gameHist
    );

    modport slave (
        input  gameSig, abortSig, answerAck, symValid, symSpecial, symData,
        output startGen, stopGen, genEnable, answerSig, numSpecial, gameTime, gameHist
    );

endinterface

// File: rtl/game_period_ctrl_prescaler.sv
// game_tick_prescaler: divides Clk100M down to a one-cycle tick per game second
module game_tick_prescaler #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic Clk100M,
    input  logic Rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              W    = $clog2(TICKS_PER_SEC);
    localparam logic [W-1:0]    LAST = W'(TICKS_PER_SEC - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // count 0..TICKS_PER_SEC-1 while enabled, restart from zero whenever cleared
    always_ff @(posedge Clk100M or posedge Rst) begin
        if (Rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/game_period_ctrl.sv
// game_period_ctrl: runs one timed symbol-generation period, keeps symbol history and special count
module game_period_ctrl
    import game_pkg::*;
#(
    parameter int               TICKS_PER_SEC = 100000000,
    parameter int               PERIOD_SECS   = 15,
    parameter int               HIST_DEPTH    = 4,
    parameter int               SYM_W         = DEF_SYM_W,
    parameter int               CNT_W         = 8,
    parameter logic [SYM_W-1:0] HIST_INIT     = SYM_W'(DEF_HIST_INIT)
) (
    input  logic        Clk100M,
    input  logic        Rst,
    game_period_ctrl_if.slave bus
);

    localparam int HW = HIST_DEPTH * SYM_W;

    localparam logic [1:0] ST_IDLE   = GS_IDLE;
    localparam logic [1:0] ST_RUN    = GS_RUN;
    localparam logic [1:0] ST_ANSWER = GS_ANSWER;

    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(PERIOD_SECS);
    localparam logic [HW-1:0]    HIST_RST = {HIST_DEPTH{HIST_INIT}};

    logic [1:0]       state;
    logic             startGenReg;
    logic             stopGenReg;
    logic             genEnableReg;
    logic             answerSigReg;
    logic [CNT_W-1:0] numSpecialReg;
    logic [SEC_W-1:0] gameTimeReg;
    logic [HW-1:0]    histReg;
    logic [SEC_W-1:0] nextTime;
    logic             running;
    logic             tick;

    assign running  = (state == ST_RUN);
    assign nextTime = gameTimeReg + 1'b1;

    game_tick_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_prescaler (
        .Clk100M (Clk100M),
        .Rst     (Rst),
        .clr     (!running),
        .en      (running),
        .tick    (tick)
    );

    // period FSM: start from IDLE, count seconds in RUN, hold the answer request until acked
    always_ff @(posedge Clk100M or posedge Rst) begin
        if (Rst) begin
            state        <= ST_IDLE;
            startGenReg  <= 1'b0;
            stopGenReg   <= 1'b0;
            genEnableReg <= 1'b0;
            answerSigReg <= 1'b0;
            gameTimeReg  <= '0;
        end else begin
            startGenReg <= 1'b0;
            stopGenReg  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.gameSig) begin
                        state        <= ST_RUN;
                        startGenReg  <= 1'b1;
                        genEnableReg <= 1'b1;
                        gameTimeReg  <= '0;
                    end
                end
                ST_RUN: begin
                    if (bus.abortSig) begin
                        state        <= ST_IDLE;
                        stopGenReg   <= 1'b1;
                        genEnableReg <= 1'b0;
                    end else if (tick) begin
                        gameTimeReg <= nextTime;
                        if (nextTime == LAST_SEC) begin
                            state        <= ST_ANSWER;
                            stopGenReg   <= 1'b1;
                            genEnableReg <= 1'b0;
                            answerSigReg <= 1'b1;
                        end
                    end
                end
                ST_ANSWER: begin
                    if (bus.answerAck) begin
                        state        <= ST_IDLE;
                        answerSigReg <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    genEnableReg <= 1'b0;
                    answerSigReg <= 1'b0;
                end
            endcase
        end
    end

    // history shift and saturating special count; reloaded on start, frozen outside RUN
    always_ff @(posedge Clk100M or posedge Rst) begin
        if (Rst) begin
            histReg       <= HIST_RST;
            numSpecialReg <= '0;
        end else if (state == ST_IDLE && bus.gameSig) begin
            histReg       <= HIST_RST;
            numSpecialReg <= '0;
        end else if (running && bus.symValid) begin
            histReg <= (histReg << SYM_W) | HW'(bus.symData);
            if (bus.symSpecial && numSpecialReg != '1)
                numSpecialReg <= numSpecialReg + 1'b1;
        end
    end

    assign bus.startGen   = startGenReg;
    assign bus.stopGen    = stopGenReg;
    assign bus.genEnable  = genEnableReg;
    assign bus.answerSig  = answerSigReg;
    assign bus.numSpecial = numSpecialReg;
    assign bus.gameTime   = gameTimeReg;
    assign bus.gameHist   = histReg;

endmodule
